// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Four-requester round-robin arbiter feeding a 4:1 data mux. A requester
//   holds the grant for up to BURST_LEN transfers, or until it drops its
//   valid. Every release costs one IDLE cycle before the next arbitration.
//   The released requester becomes lowest priority for the next pick.
//
// Parameters
//   DATA_W     width of each requester data word
//   BURST_LEN  max transfers per grant, legal range 1..16
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   per-requester valid, bit i = requester i
//   in_data    requester data, requester i at [i*DATA_W +: DATA_W]
//   in_ready   per-requester ready, at most one bit set
//   out_valid  valid of the selected requester
//   out_data   data of the selected requester
//   out_ready  downstream ready
//   sel        registered 4:1 select code
//   grant      registered one-hot grant, zero when idle
//   grant_cnt  per-requester 16-bit grant counters, requester i at
//              [i*16 +: 16]; present only when MUX_ARB_GRANT_CNT_EN is defined
//
// Build option
//   MUX_ARB_GRANT_CNT_EN  adds grant_cnt and its counters

module mux_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic [1:0]          sel,
    output logic [3:0]          grant
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    output logic [4*16-1:0]     grant_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  sel_nxt;
    logic [3:0]  grant_nxt;
    logic [3:0]  beat, beat_nxt;
    logic [1:0]  pick;
    logic        xfer;
    logic [DATA_W-1:0] data_arr [4];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            data_arr[i] = in_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan from ptr upward, wrapping mod 4; first valid requester wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        beat_nxt  = beat;
        in_ready  = '0;
        out_valid = 1'b0;
        out_data  = data_arr[sel];
        xfer      = 1'b0;

        case (state)
            IDLE: begin
                if (|in_valid) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick;
                    grant_nxt = 4'b0001 << pick;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                out_valid     = in_valid[sel];
                in_ready[sel] = out_ready;
                xfer          = out_valid && out_ready;
                // Release on the last beat or as soon as the owner drops valid;
                // sel is kept so out_data keeps showing the last owner in IDLE.
                if (!in_valid[sel] || (xfer && beat == LAST_BEAT)) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = sel + 2'd1;
                end else if (xfer) begin
                    beat_nxt = beat + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            grant <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            grant <= grant_nxt;
            beat  <= beat_nxt;
        end
    end

`ifdef MUX_ARB_GRANT_CNT_EN
    logic [15:0] cnt [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == IDLE && |in_valid) begin
            cnt[pick] <= cnt[pick] + 16'd1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            grant_cnt[i*16 +: 16] = cnt[i];
        end
    end
`endif

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of each requester data word.
REQ-002 Parameter BURST_LEN, default 4: max beats per grant, legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  4  per-requester valid; bit i = requester i.
REQ-006 in_data  input  4*DATA_W  requester data; requester i at bits [i*DATA_W +: DATA_W].
REQ-007 in_ready  output  4  per-requester ready; at most one bit set.
REQ-008 out_valid  output  1  valid of the selected requester.
REQ-009 out_data  output  DATA_W  data of the selected requester (4:1 select by sel).
REQ-010 out_ready  input  1  downstream ready.
REQ-011 sel  output  2  current 4:1 select code, registered.
REQ-012 grant  output  4  one-hot grant, registered; all zero when idle.
REQ-013 grant_cnt  output  4*16  per-requester grant counters (present only with MUX_ARB_GRANT_CNT_EN).

Function
REQ-014 FSM states: IDLE, GRANT.
REQ-015 IDLE, in_valid != 0: pick first requester with in_valid set, scanning from ptr upward mod 4; load sel, set grant one-hot, beat count = 0, go to GRANT next cycle.
REQ-016 IDLE, in_valid == 0: stay in IDLE; grant = 0, in_ready = 0, out_valid = 0.
REQ-017 GRANT: out_valid = in_valid[sel], out_data = in_data[sel], in_ready[sel] = out_ready, other in_ready bits 0 (combinational pass-through, zero latency).
REQ-018 Transfer = out_valid && out_ready; each transfer increments beat count.
REQ-019 GRANT release: on a transfer with beat count == BURST_LEN-1, or on any cycle with in_valid[sel] == 0; next state IDLE, grant = 0, ptr = sel+1 mod 4.
REQ-020 out_ready low with in_valid[sel] high: hold state, count, sel, and grant; no timeout.
REQ-021 Release always costs one IDLE cycle (arbitration bubble) before the next grant.
REQ-022 Released requester takes lowest priority in the next arbitration; ptr wraps from 3 to 0.
REQ-023 BURST_LEN = 1: release after every transfer; throughput is 1 beat per 2 cycles.
REQ-024 Changes to in_valid on non-granted requesters during GRANT have no effect on the current grant.
REQ-025 In IDLE, out_data = in_data[sel] (last sel); out_valid is 0.

Reset
REQ-026 While rst is high at a clock edge: state = IDLE, ptr = 0, sel = 0, grant = 0, beat count = 0, all grant_cnt = 0.
REQ-027 Reset mid-burst abandons the burst; in_ready = 0 and out_valid = 0 from the first cycle after the reset edge.
REQ-028 After reset, requester 0 has highest priority.

Configuration
REQ-029 Macro MUX_ARB_GRANT_CNT_EN defined: grant_cnt port exists; counter i increments by 1 on each IDLE->GRANT transition for requester i and wraps 0xFFFF->0.
REQ-030 Macro MUX_ARB_GRANT_CNT_EN undefined: grant_cnt port and counters are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then in_valid=4'b1010 held, out_ready=1, BURST_LEN=4 -> requester 1 granted (sel=1) for 4 beats, 1 idle cycle, then requester 3 for 4 beats, then requester 1.
REQ-032 in_valid=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0; each burst 4 transfers; in_ready is never multi-hot.
REQ-033 Requester 2 granted, out_ready low for 5 cycles after beat 2 -> sel=2 held, count held, burst completes with 2 more beats after out_ready returns.
REQ-034 Requester 0 drops in_valid after 2 beats -> release that cycle, IDLE next cycle, ptr=1, requester 1 granted if valid.
REQ-035 rst asserted during beat 3 of requester 3 -> next cycle grant=0, sel=0, in_ready=0; after deassert with in_valid=4'b1001, requester 0 granted.
REQ-036 With MUX_ARB_GRANT_CNT_EN, 3 grants to requester 2 -> grant_cnt for requester 2 = 3, others unchanged; counter preset to 0xFFFF wraps to 0 on the next grant.
